// File: rtl/spi_tx_burst_master.sv
// spi_tx_burst_master
//   SPI transmit master for the display link (cs/dc/scl/sda). Words of
//   {dc, data} are queued in a FIFO and shifted MSB first. Words that follow
//   each other without a gap share one CS-low burst. The SCL rate and the SPI
//   mode (CPOL/CPHA) can be changed at runtime. They are captured when a burst
//   starts and held until the burst ends.
//
//   Optional feature macro: SPI_TX_DC_BREAK_EN
//     defined   : a change of dc between consecutive words ends the burst,
//                 and the next word starts a fresh CS-low burst.
//     undefined : dc switches at the word boundary and cs stays low.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   wr_en        push {wr_dc, wr_data} into the FIFO (dropped when full)
//   wr_data      word to send
//   wr_dc        dc level of the word (0 = command, 1 = data)
//   clk_div      SCL half-period = clk_div+1 clk cycles
//   cpol         SCL idle level
//   cpha         0: sample on leading edge, 1: sample on trailing edge
//   full/empty   FIFO status
//   level        FIFO occupancy, 0..FIFO_DEPTH
//   busy         engine is not in IDLE
//   cs/dc/scl/sda  panel pins (all registered)
//   dbg_state_o  current engine state, for debug and checkers
//
// Handshake: the write side has no back-pressure. A word is accepted on any
// clk edge where wr_en=1 and full=0, and it is silently dropped when full=1.
module spi_tx_burst_master #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_dc,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic                          cpol,
  input  logic                          cpha,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          cs,
  output logic                          dc,
  output logic                          scl,
  output logic                          sda,
  output logic [2:0]                    dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
  logic              mem_dc_q   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q;
  logic              push_ok;
  logic              pop;
  logic [DATA_W-1:0] head_data;
  logic              head_dc;

  assign empty     = (count_q == '0);
  assign full      = (count_q == LW'(FIFO_DEPTH));
  assign level     = count_q;
  assign push_ok   = wr_en && !full;
  assign head_data = mem_data_q[rd_ptr_q];
  assign head_dc   = mem_dc_q[rd_ptr_q];

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data_q[wr_ptr_q] <= wr_data;
      mem_dc_q[wr_ptr_q]   <= wr_dc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- shift engine ----------------
  state_e            state_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q, cpha_q;
  logic [EW-1:0]     edge_q;
  logic [DATA_W-1:0] shreg_q;
  logic              cs_q, dc_q, scl_q, sda_q;
  logic              tick;
  logic              cont;

  assign tick = (cnt_q == div_q);

  // Whether the burst may continue with the word at the FIFO head.
`ifdef SPI_TX_DC_BREAK_EN
  assign cont = !empty && (head_dc == dc_q);
`else
  assign cont = !empty;
`endif

  always_comb begin
    pop = 1'b0;
    if (state_q == S_IDLE && !empty) pop = 1'b1;
    if (state_q == S_SHIFT && tick && edge_q == LAST_EDGE && cont) pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      edge_q  <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      scl_q   <= cpol;
      sda_q   <= 1'b0;
    end else begin
      // The divider runs freely in every active state and restarts on each tick.
      if (state_q != S_IDLE) cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          cs_q  <= 1'b1;
          scl_q <= cpol;
          if (!empty) begin
            state_q <= S_LEAD;
            cs_q    <= 1'b0;
            div_q   <= clk_div;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            dc_q    <= head_dc;
            // With cpha=0 the first bit must be on sda before the first edge.
            if (!cpha) begin
              sda_q   <= head_data[DATA_W-1];
              shreg_q <= {head_data[DATA_W-2:0], 1'b0};
            end else begin
              shreg_q <= head_data;
            end
          end
        end

        S_LEAD: begin
          scl_q <= cpol_q;
          if (tick) begin
            state_q <= S_SHIFT;
            edge_q  <= '0;
          end
        end

        S_SHIFT: begin
          if (tick) begin
            scl_q  <= ~scl_q;
            edge_q <= edge_q + EW'(1);
            if (!edge_q[0]) begin
              // Leading edge: cpha=1 launches the next bit here.
              if (cpha_q) begin
                sda_q   <= shreg_q[DATA_W-1];
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
              end
            end else if (edge_q != LAST_EDGE) begin
              // Trailing edge: cpha=0 launches the next bit here.
              if (!cpha_q) begin
                sda_q   <= shreg_q[DATA_W-1];
                shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
              end
            end else begin
              // Word boundary: chain the next word or close the burst.
              edge_q <= '0;
              if (cont) begin
                dc_q <= head_dc;
                if (!cpha_q) begin
                  sda_q   <= head_data[DATA_W-1];
                  shreg_q <= {head_data[DATA_W-2:0], 1'b0};
                end else begin
                  shreg_q <= head_data;
                end
              end else begin
                state_q <= S_TRAIL;
              end
            end
          end
        end

        S_TRAIL: begin
          scl_q <= cpol_q;
          if (tick) begin
            cs_q    <= 1'b1;
            state_q <= S_GAP;
          end
        end

        S_GAP: begin
          if (tick) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign cs          = cs_q;
  assign dc          = dc_q;
  assign scl         = scl_q;
  assign sda         = sda_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_tx_burst_master.sv
module tb_spi_tx_burst_master;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_dc;
  logic [7:0] clk_div;
  logic       cpol, cpha;
  logic       full, empty, busy, cs, dc, scl, sda;
  logic [4:0] level;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  spi_tx_burst_master #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dc(wr_dc),
    .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .full(full), .empty(empty),
    .level(level), .busy(busy), .cs(cs), .dc(dc), .scl(scl), .sda(sda),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- pin monitor (samples on negedge) ----------------
  logic       prev_scl, prev_sda, prev_cs, prev_dc;
  logic [7:0] rx_word;
  int bit_cnt = 0, bursts = 0, cs_low_cnt = 0, last_low = 0;
  int cs_high_cnt = 0, last_high = 0, gap_cnt = 0, last_gap = 0;
  int scl_edges = 0, dc_mid_rise = 0;

  always @(negedge clk) begin
    if (!reset) begin
      bit_cnt = 0;
      cs_low_cnt = 0;
    end else begin
      if (prev_cs == 1'b0 && cs == 1'b1) begin
        bursts++;
        last_low = cs_low_cnt;
        cs_low_cnt = 0;
        cs_high_cnt = 0;
        bit_cnt = 0;
      end
      if (prev_cs == 1'b1 && cs == 1'b0) last_high = cs_high_cnt;
      if (cs == 1'b0) cs_low_cnt++;
      else cs_high_cnt++;
      if (dc && !prev_dc && !cs && !prev_cs) dc_mid_rise++;
      if (scl != prev_scl) begin
        scl_edges++;
        last_gap = gap_cnt;
        gap_cnt = 1;
        // Leading edge moves scl away from its idle level; a slave samples
        // the data that was on the line just before the edge.
        if (!cs && ((scl != cpol) == !cpha)) begin
          rx_word = {rx_word[6:0], prev_sda};
          bit_cnt++;
          if (bit_cnt == DW) begin
            bit_cnt = 0;
            if (exp_q.size() > 0) check("rx_word", {23'd0, prev_dc, rx_word}, {23'd0, exp_q.pop_front()});
            else check("rx_extra", {23'd0, prev_dc, rx_word}, 32'hFFFF_FFFF);
          end
        end
      end else begin
        gap_cnt++;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
    prev_cs  = cs;
    prev_dc  = dc;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic d_c, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_dc   = d_c;
    wr_data = d;
    exp_q.push_back({d_c, d});
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || !empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

`ifdef SPI_TX_DC_BREAK_EN
  localparam int EXP_T5_BURSTS = 2;
  localparam int EXP_T5_DCMID  = 0;
`else
  localparam int EXP_T5_BURSTS = 1;
  localparam int EXP_T5_DCMID  = 1;
`endif

  // ---------------- stimulus ----------------
  initial begin
    int b0;
    int e0;
    int n;
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dc = 1'b0;
    clk_div = 8'd0; cpol = 1'b0; cpha = 1'b0;
    idle(3);

    // Reset state
    check("rst_cs", {31'd0, cs}, 32'd1);
    check("rst_scl", {31'd0, scl}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd0);
    check("rst_dc", {31'd0, dc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_level", {27'd0, level}, 32'd0);
    reset = 1'b1;
    idle(2);

    // Test 1: single word 0xA5, mode 0, clk_div=0
    b0 = bursts;
    push(1'b0, 8'hA5);
    check("t1_cs_after_push", {31'd0, cs}, 32'd1);
    check("t1_level", {27'd0, level}, 32'd1);
    @(negedge clk);
    check("t1_cs_fall", {31'd0, cs}, 32'd0);
    wait_idle(200);
    check("t1_bursts", bursts - b0, 32'd1);
    check("t1_cs_low", last_low, 32'd18);
    check("t1_cs_end", {31'd0, cs}, 32'd1);
    idle(3);

    // Test 2: three words back-to-back, clk_div=3
    clk_div = 8'd3;
    idle(2);
    b0 = bursts;
    push(1'b0, 8'h11);
    push(1'b0, 8'h29);
    push(1'b0, 8'h3C);
    wait_idle(1000);
    check("t2_bursts", bursts - b0, 32'd1);
    check("t2_cs_low", last_low, 32'd200);
    check("t2_half_period", last_gap, 32'd4);
    idle(3);

    // Test 3: modes 1..3 with 0x81
    clk_div = 8'd1;
    for (int m = 1; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      idle(3);
      check("t3_scl_idle_pre", {31'd0, scl}, {31'd0, cpol});
      push(1'b0, 8'h81);
      wait_idle(300);
      idle(2);
      check("t3_scl_idle_post", {31'd0, scl}, {31'd0, cpol});
    end
    check("t3_drained", exp_q.size(), 32'd0);

    // Test 4: overfill the FIFO, mode 0, clk_div=0
    cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0;
    idle(3);
    for (int i = 0; i < 18; i++) begin
      wr_en   = 1'b1;
      wr_dc   = i[0];
      wr_data = 8'h40 + 8'(i);
      if (i < 17) exp_q.push_back({i[0], 8'h40 + 8'(i)});
      @(negedge clk);
      if (i == 16) begin
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_level16", {27'd0, level}, 32'd16);
      end
      if (i == 17) begin
        check("t4_drop_level", {27'd0, level}, 32'd16);
        check("t4_drop_full", {31'd0, full}, 32'd1);
      end
    end
    wr_en = 1'b0;
    wait_idle(3000);
    check("t4_drained", exp_q.size(), 32'd0);
    idle(3);

    // Test 5: dc change between words
    b0 = bursts;
    dc_mid_rise = 0;
    push(1'b0, 8'h2C);
    push(1'b1, 8'hFF);
    wait_idle(300);
    check("t5_bursts", bursts - b0, EXP_T5_BURSTS);
    check("t5_dc_mid_rise", dc_mid_rise, EXP_T5_DCMID);
    check("t5_cs_high_min", {31'd0, last_high >= 1}, 32'd1);
    check("t5_dc_final", {31'd0, dc}, 32'd1);
    idle(3);

    // Test 6: reset in the middle of 0xF0, mode 2, clk_div=3
    cpol = 1'b1; cpha = 1'b0; clk_div = 8'd3;
    idle(3);
    push(1'b0, 8'hF0);
    void'(exp_q.pop_back());
    n = 0;
    while (bit_cnt != 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_bit4", {31'd0, n < 500}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_cs", {31'd0, cs}, 32'd1);
    check("t6_scl", {31'd0, scl}, 32'd1);
    check("t6_level", {27'd0, level}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_dc", {31'd0, dc}, 32'd0);
    e0 = scl_edges;
    idle(3);
    reset = 1'b1;
    idle(40);
    check("t6_no_scl_edges", scl_edges - e0, 32'd0);
    check("t6_cs_stays_high", {31'd0, cs}, 32'd1);

    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
